// File: rtl/jdivider_pkg.sv
// Shared types and constants for the restoring divider.
//   state_e            : divider FSM states (IDLE, CALC, DONE)
//   DIV_DEFAULT_WIDTH  : default operand/quotient/remainder width
package jdivider_pkg;

    localparam int DIV_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/jcla_subtractor.sv
// Carry-lookahead subtractor: diff = a - b.
// Same generate/propagate structure as the team CLA adder, with b inverted
// internally and carry-in tied high (two's complement subtraction).
//   a_i        : minuend
//   b_i        : subtrahend
//   diff_o     : a_i - b_i (modulo 2^N)
//   carryout_o : 1 = no borrow (a_i >= b_i), 0 = borrow
module jcla_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         carryout_o
);

    logic [N-1:0] b_n;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         acc;
    logic         run;

    assign b_n = ~b_i;
    assign g   = a_i & b_n;
    assign p   = a_i ^ b_n;

    // Each carry is expanded in flat lookahead form from g/p and the tied-high
    // carry-in, so no carry depends on a previously computed carry.
    always_comb begin
        c    = '0;
        c[0] = 1'b1;
        acc  = 1'b0;
        run  = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                run = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    run = run & p[k];
                end
                acc = acc | run;
            end
            run = 1'b1;
            for (int k = 0; k <= i; k++) begin
                run = run & p[k];
            end
            acc      = acc | run;
            c[i + 1] = acc;
        end
    end

    assign diff_o     = p ^ c[N-1:0];
    assign carryout_o = c[N];

endmodule

// File: rtl/jrestoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Trial subtraction uses the CLA subtractor.
//   clk_i          : rising-edge clock
//   reset_i        : synchronous active-high reset
//   start_i        : request a division (sampled only while not busy)
//   dividend_i     : numerator, captured on accepted start
//   divisor_i      : denominator, captured on accepted start
//   busy_o         : high while iterating
//   done_o         : one-cycle pulse, results valid and updated
//   quotient_o     : registered quotient, held until next completion
//   remainder_o    : registered remainder, held until next completion
//   div_by_zero_o  : registered flag for the last completed operation
//
// state | meaning
// IDLE  | waiting for start
// CALC  | shifting/subtracting, one quotient bit per edge
// DONE  | done pulse; a new start may be accepted in this cycle
module jrestoring_divider
    import jdivider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // The partial remainder is always below the divisor after each step, so
    // the top bit of the (WIDTH+1)-bit P register is always zero and is not
    // stored; it reappears only as the bit shifted in from the left.
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   sub_diff;
    logic             sub_nobrw;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] q_d;
    logic             diff_msb_unused;

    assign p_shift = {p_q, q_q[WIDTH-1]};
    assign q_shift = {q_q[WIDTH-2:0], 1'b0};

    jcla_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a_i        (p_shift),
        .b_i        ({1'b0, divisor_q}),
        .diff_o     (sub_diff),
        .carryout_o (sub_nobrw)
    );

    // When no borrow occurs the result is below the divisor, so its MSB is 0.
    assign diff_msb_unused = sub_diff[WIDTH];

    assign p_d = sub_nobrw ? sub_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
    assign q_d = {q_shift[WIDTH-1:1], sub_nobrw};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            p_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start_i) begin
                        if (divisor_i != '0) begin
                            divisor_q <= divisor_i;
                            p_q       <= '0;
                            q_q       <= dividend_i;
                            count_q   <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= CALC;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= dividend_i;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                CALC: begin
                    p_q     <= p_d;
                    q_q     <= q_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        quotient_q  <= q_d;
                        remainder_q <= p_d;
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_jrestoring_divider.sv
// Self-checking bench for jrestoring_divider (WIDTH=4): directed table,
// handshake corner sequences, random and exhaustive operand sweeps.
module tb_jrestoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;
    int last_q = 0;
    int last_r = 0;

    typedef struct {
        int a;
        int b;
        int eq;
        int er;
        int edz;
    } vec_t;

    vec_t vecs[6];

    jrestoring_divider #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Present a start for one edge, then scramble the operand inputs.
    task automatic issue(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Wait for done after an accepted start; leaves time inside the DONE cycle.
    task automatic wait_check(input int a, input int b, input int eq,
                              input int er, input int edz, input string tag);
        int n = 0;
        int busy_n = 0;
        int held = 1;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if (int'(quotient) != last_q || int'(remainder) != last_r) held = 0;
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("%s latency %0d/%0d", tag, a, b), n, (b == 0) ? 0 : W);
        check($sformatf("%s busy cycles %0d/%0d", tag, a, b), busy_n, (b == 0) ? 0 : W);
        check($sformatf("%s held %0d/%0d", tag, a, b), held, 1);
        check($sformatf("%s quotient %0d/%0d", tag, a, b), int'(quotient), eq);
        check($sformatf("%s remainder %0d/%0d", tag, a, b), int'(remainder), er);
        check($sformatf("%s dbz %0d/%0d", tag, a, b), int'(div_by_zero), edz);
        last_q = eq;
        last_r = er;
    endtask

    task automatic run_div(input int a, input int b, input int eq,
                           input int er, input int edz, input string tag);
        issue(a, b);
        wait_check(a, b, eq, er, edz, tag);
        @(posedge clk);
        #1;
        check($sformatf("%s done pulse width %0d/%0d", tag, a, b), int'(done), 0);
    endtask

    initial begin
        int extra;
        int n;

        vecs[0] = '{13, 3, 4, 1, 0};
        vecs[1] = '{15, 1, 15, 0, 0};
        vecs[2] = '{7, 10, 0, 7, 0};
        vecs[3] = '{15, 15, 1, 0, 0};
        vecs[4] = '{0, 5, 0, 0, 0};
        vecs[5] = '{9, 0, 15, 9, 1};

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset dbz", int'(div_by_zero), 0);

        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, "table");
        end

        // Start pulsed while busy must be ignored.
        issue(12, 5);
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 4'd3;
        divisor  = 4'd1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'd15;
        divisor  = 4'd2;
        n = 2;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignored-start latency", n, W);
        check("ignored-start quotient", int'(quotient), 2);
        check("ignored-start remainder", int'(remainder), 2);
        last_q = 2;
        last_r = 2;
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("ignored-start extra done", extra, 0);

        // Reset at the second CALC edge aborts the operation.
        issue(14, 4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort quotient", int'(quotient), 0);
        check("abort remainder", int'(remainder), 0);
        check("abort dbz", int'(div_by_zero), 0);
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("abort no done", extra, 0);
        last_q = 0;
        last_r = 0;
        run_div(14, 4, 3, 2, 0, "after-abort");

        // Back-to-back: new start accepted in the DONE cycle.
        issue(6, 4);
        wait_check(6, 4, 1, 2, 0, "b2b first");
        check("b2b busy in DONE", int'(busy), 0);
        issue(11, 2);
        wait_check(11, 2, 5, 1, 0, "b2b second");
        issue(5, 0);
        wait_check(5, 0, 15, 5, 1, "b2b dbz");
        @(posedge clk);
        #1;

        repeat (40) begin
            int a = int'($urandom_range(0, 15));
            int b = int'($urandom_range(0, 15));
            run_div(a, b, ref_q(a, b), ref_r(a, b), (b == 0) ? 1 : 0, "rand");
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a, b, ref_q(a, b), ref_r(a, b), (b == 0) ? 1 : 0, "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jrestoring_divider.md
Name: jrestoring_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the team's 4-bit carry-lookahead adder.
- Computes quotient and remainder one bit per clock.
- Each trial subtraction is done by a carry-lookahead subtractor, built as the CLA adder structure with the B input inverted and carry-in tied to 1.
- Sits beside the adder in the arithmetic block set as its sequential counterpart, with a start/done handshake.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal 2..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  WIDTH  numerator, captured on accepted start.
- divisor  input  WIDTH  denominator, captured on accepted start.
- busy  output  1  high while iterating (CALC state).
- done  output  1  one-cycle pulse: results valid and updated.
- quotient  output  WIDTH  registered result, held until the next completion.
- remainder  output  WIDTH  registered result, held until the next completion.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: start=1 with divisor!=0 -> capture operands; P (WIDTH+1 bits)=0, Q=dividend, count=0 -> CALC. start=1 with divisor==0 -> DONE.
  - CALC: each edge shifts {P,Q} left by 1, then computes T = P_shifted - {0,divisor} on the (WIDTH+1)-bit subtractor. Carry-out=1 (no borrow) -> P=T, Q[0]=1. Carry-out=0 -> P=P_shifted (restore), Q[0]=0. count increments; after WIDTH iterations -> DONE.
  - DONE: done=1 for exactly one cycle. quotient/remainder/div_by_zero were loaded on the edge entering DONE. Next state is IDLE, or CALC if start=1 is accepted in this cycle (busy=0 in DONE).
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH (WIDTH+1 cycles). Divide-by-zero: done high in the cycle after edge k (1 cycle).
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- Normal completion: quotient=Q, remainder=P[WIDTH-1:0], div_by_zero=0. Result satisfies dividend = quotient*divisor + remainder and remainder < divisor.
- start while busy=1 is ignored; operands are not re-sampled, so mid-operation input changes have no effect.
- Outputs change only on the edge entering DONE or on reset; they are stable at all other times.
- Boundaries:
  - dividend=0 -> q=0, r=0.
  - divisor > dividend -> q=0, r=dividend.
  - divisor=1 -> q=dividend, r=0.
  - max/max -> q=1, r=0.

Decomposition:
- Package jdivider_pkg holds the state enum (IDLE, CALC, DONE) and the DIV_DEFAULT_WIDTH=4 constant.
- Sub-module jcla_subtractor (parameter N): Y = A - B via generate/propagate carry-lookahead with internal B inversion and carry-in=1; outputs diff[N-1:0] and carryout (1 = no borrow). Instantiated once with N=WIDTH+1.
- The FSM, counter and shift registers live in jrestoring_divider.

Test Plan:
- Reset then start with dividend=13, divisor=3 -> busy high 4 cycles; done pulses 5 cycles after the start edge; quotient=4, remainder=1, div_by_zero=0.
- dividend=15/divisor=1 -> q=15, r=0. dividend=7/divisor=10 -> q=0, r=7. dividend=15/divisor=15 -> q=1, r=0. dividend=0/divisor=5 -> q=0, r=0.
- dividend=9, divisor=0 -> done in the cycle after the start edge; q=15, r=9, div_by_zero=1; busy never asserts.
- Start 12/5; pulse start with 3/1 and change the operands while busy -> ignored; the single done gives q=2, r=2.
- Start 14/4; assert reset at the 2nd CALC edge -> all outputs 0, no done pulse. A new 14/4 then gives q=3, r=2.
- Back-to-back: start asserted during the DONE cycle -> the new operation begins immediately; prior results are held until its done. Finish with an exhaustive 16x16 sweep checked against the arithmetic reference.
